// File: rtl/delay_timer_arbiter_if.sv
// Request/grant/done bundle between requesters and the shared delay timer.
// Optional abort signal present when DTA_ABORT_EN is defined.
interface delay_timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CNTW = 10,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ*CNTW-1:0] delay_in;
`ifdef DTA_ABORT_EN
    logic                 abort;
`endif
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic [IDW-1:0]       cur_id;
    logic [CNTW-1:0]      remaining;

`ifdef DTA_ABORT_EN
    modport master (
        output req, delay_in, abort,
        input  grant, done, busy, cur_id, remaining
    );
    modport slave (
        input  req, delay_in, abort,
        output grant, done, busy, cur_id, remaining
    );
`else
    modport master (
        output req, delay_in,
        input  grant, done, busy, cur_id, remaining
    );
    modport slave (
        input  req, delay_in,
        output grant, done, busy, cur_id, remaining
    );
`endif
endinterface

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter in front of one shared programmable down-counter: grant, count, done.
// Optional feature macro: DTA_ABORT_EN adds an abort input that cancels the running job.
module delay_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 10,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    delay_timer_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [IDW-1:0]  PTR_RST  = IDW'(NREQ - 1);
    localparam logic [IDW-1:0]  ID_ZERO  = {IDW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0] VEC_ZERO = {NREQ{1'b0}};
    localparam logic [NREQ-1:0] VEC_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [CNTW-1:0] rem_q, rem_d;

    logic            win_vld_s;
    logic [IDW-1:0]  win_id_s;
    logic [CNTW-1:0] win_delay_s;
    logic            abort_s;

    // Scan requesters starting just after the last winner; returns {valid, index}.
    function automatic logic [IDW:0] rr_pick(input logic [IDW-1:0] ptr,
                                             input logic [NREQ-1:0] req);
        logic [IDW-1:0] idx;
        logic           found;
        logic [IDW-1:0] sel;
        found = 1'b0;
        sel   = ID_ZERO;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

`ifdef DTA_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    // Arbitration and delay-slice selection for the would-be winner.
    always_comb begin
        win_delay_s           = CNT_ZERO;
        {win_vld_s, win_id_s} = rr_pick(ptr_q, bus.req);
        for (int i = 0; i < NREQ; i++) begin
            if (win_id_s == IDW'(i)) begin
                win_delay_s = bus.delay_in[i*CNTW +: CNTW];
            end else begin
                win_delay_s = win_delay_s;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_id_d = cur_id_q;
        grant_d  = VEC_ZERO;
        done_d   = VEC_ZERO;
        busy_d   = busy_q;
        rem_d    = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_d  = ST_LOAD;
                    ptr_d    = win_id_s;
                    cur_id_d = win_id_s;
                    rem_d    = win_delay_s;
                    grant_d  = VEC_ONE << win_id_s;
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    rem_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // Abort takes precedence over completion in the same cycle.
                if (abort_s) begin
                    state_d = ST_IDLE;
                    rem_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                end else if (rem_q != CNT_ZERO) begin
                    rem_d   = rem_q - CNT_ONE;
                end else begin
                    state_d = ST_DONE;
                    done_d  = VEC_ONE << cur_id_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                rem_d   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RST;
            cur_id_q <= ID_ZERO;
            grant_q  <= VEC_ZERO;
            done_q   <= VEC_ZERO;
            busy_q   <= 1'b0;
            rem_q    <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_id_q <= cur_id_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rem_q    <= rem_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.cur_id    = cur_id_q;
    assign bus.remaining = rem_q;
endmodule
